// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one operand bit per cycle,
// with saturating overflow and a leading-zero mask registered on completion.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   opd_q, opd_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  lz_q, lz_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [BIN_W-1:0]   opd_shift;
    logic               ovf_fin;
    logic [BCD_W-1:0]   res;
    logic [DIGITS-1:0]  lz_res;
    logic               allz;

    // One double-dabble step: add 3 to digits >= 5, then shift operand MSB in.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        scr_shift = {adj[BCD_W-2:0], opd_q[BIN_W-1]};
        opd_shift = {opd_q[BIN_W-2:0], 1'b0};
        ovf_fin   = ovf_scr_q | adj[BCD_W-1];
        res       = ovf_fin ? {DIGITS{4'h9}} : scr_shift;
    end

    // Saturated results are all nines, so the mask falls out as zero on overflow.
    always_comb begin
        lz_res = '0;
        allz   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allz      = allz & (res[4*i +: 4] == 4'd0);
            lz_res[i] = allz;
        end
    end

    always_comb begin
        state_d   = state_q;
        opd_d     = opd_q;
        scr_d     = scr_q;
        ovf_scr_d = ovf_scr_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        lz_d      = lz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opd_d     = bin;
                    scr_d     = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                opd_d     = opd_shift;
                scr_d     = scr_shift;
                ovf_scr_d = ovf_fin;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    bcd_d   = res;
                    ovf_d   = ovf_fin;
                    lz_d    = lz_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opd_q     <= '0;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            lz_q      <= '0;
        end else begin
            state_q   <= state_d;
            opd_q     <= opd_d;
            scr_q     <= scr_d;
            ovf_scr_q <= ovf_scr_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            lz_q      <= lz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign lz_mask  = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three parameterisations (8/3, 8/2, 16/5)
// sharing one clock and reset, checked with immediate assertions.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [7:0]  bin_a;
    logic [11:0] bcd_a;
    logic [2:0]  lz_a;

    logic        start_b, busy_b, done_b, ovf_b;
    logic [7:0]  bin_b;
    logic [7:0]  bcd_b;
    logic [1:0]  lz_b;

    logic        start_c, busy_c, done_c, ovf_c;
    logic [15:0] bin_c;
    logic [19:0] bcd_c;
    logic [4:0]  lz_c;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int dones;
    logic [11:0] cap;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .lz_mask(lz_a));

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .lz_mask(lz_b));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .lz_mask(lz_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency counts edges from the one that samples start up to done.
    task automatic run_a(input logic [7:0] v, output int n);
        start_a = 1'b1; bin_a = v;
        step();
        start_a = 1'b0;
        n = 1;
        while (!done_a && n < 40) begin step(); n++; end
    endtask

    task automatic run_b(input logic [7:0] v, output int n);
        start_b = 1'b1; bin_b = v;
        step();
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 40) begin step(); n++; end
    endtask

    task automatic run_c(input logic [15:0] v, output int n);
        start_c = 1'b1; bin_c = v;
        step();
        start_c = 1'b0;
        n = 1;
        while (!done_c && n < 40) begin step(); n++; end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; bin_a = '0;
        start_b = 1'b0; bin_b = '0;
        start_c = 1'b0; bin_c = '0;
        repeat (3) step();

        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_lz", lz_a, 0);
        check("rst_bcd_c", bcd_c, 0);
        rst_n = 1'b1;
        step();

        // 255 on 8/3: latency, result, busy through done cycle
        run_a(8'd255, lat);
        check("lat_255", lat, 9);
        check("busy_at_done", busy_a, 1);
        check("bcd_255", bcd_a, 12'h255);
        check("ovf_255", ovf_a, 0);
        check("lz_255", lz_a, 3'b000);
        step();
        check("done_pulse", done_a, 0);
        check("busy_after", busy_a, 0);

        run_a(8'd0, lat);
        check("bcd_0", bcd_a, 12'h000);
        check("lz_0", lz_a, 3'b110);
        step();
        run_a(8'd7, lat);
        check("bcd_7", bcd_a, 12'h007);
        check("lz_7", lz_a, 3'b110);
        step();
        run_a(8'd42, lat);
        check("bcd_42", bcd_a, 12'h042);
        check("lz_42", lz_a, 3'b100);
        step();

        // Overflow saturation on 8/2, then the largest in-range value
        run_b(8'd100, lat);
        check("lat_b", lat, 9);
        check("ovf_100", ovf_b, 1);
        check("bcd_100", bcd_b, 8'h99);
        check("lz_100", lz_b, 2'b00);
        step();
        run_b(8'd99, lat);
        check("ovf_99", ovf_b, 0);
        check("bcd_99", bcd_b, 8'h99);
        check("lz_99", lz_b, 2'b00);
        step();

        // Start while busy is ignored: exactly one done, result of the first
        start_a = 1'b1; bin_a = 8'd12;
        step();
        start_a = 1'b0;
        step(); step();
        start_a = 1'b1; bin_a = 8'd200;
        step();
        start_a = 1'b0;
        dones = 0; cap = '0;
        for (int i = 0; i < 20; i++) begin
            if (done_a) begin dones++; cap = bcd_a; end
            step();
        end
        check("one_done", dones, 1);
        check("bcd_12", cap, 12'h012);
        check("bcd_12_hold", bcd_a, 12'h012);
        check("idle_after_12", busy_a, 0);

        // Result holds through a later conversion until its own done
        start_a = 1'b1; bin_a = 8'd42;
        step();
        start_a = 1'b0;
        step(); step(); step();
        check("hold_mid", bcd_a, 12'h012);
        check("lz_hold_mid", lz_a, 3'b100);
        lat = 0;
        while (!done_a && lat < 40) begin step(); lat++; end
        check("bcd_42b", bcd_a, 12'h042);
        step();

        // Reset on the 4th SHIFT cycle aborts with no done; start alongside is ignored
        start_a = 1'b1; bin_a = 8'd200;
        step();
        start_a = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        start_a = 1'b1; bin_a = 8'd99;
        step();
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_bcd", bcd_a, 0);
        check("abort_ovf", ovf_a, 0);
        check("abort_lz", lz_a, 0);
        check("abort_bcd_b", bcd_b, 0);
        step();
        rst_n = 1'b1;
        start_a = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a || busy_a) dones++;
            step();
        end
        check("no_done_after_abort", dones, 0);
        run_a(8'd5, lat);
        check("lat_5", lat, 9);
        check("bcd_5", bcd_a, 12'h005);
        check("lz_5", lz_a, 3'b110);
        step();

        // Wide configuration 16/5
        run_c(16'd65535, lat);
        check("lat_c", lat, 17);
        check("bcd_65535", bcd_c, 20'h65535);
        check("ovf_65535", ovf_c, 0);
        check("lz_65535", lz_c, 5'b00000);
        step();
        check("done_c_pulse", done_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3, BCD output digit count, legal range 1..10.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  conversion request; sampled only while busy=0.
REQ-006 SHALL have port bin  input  BIN_W  unsigned binary operand; captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high from the edge after start acceptance through the done cycle inclusive.
REQ-008 SHALL have port done  output  1  single-cycle pulse when the result is valid.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-010 SHALL have port overflow  output  1  high when bin >= 10^DIGITS in the last conversion.
REQ-011 SHALL have port lz_mask  output  DIGITS  bit i high when digit i is a leading zero; bit 0 always 0.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE is the reset state.
REQ-013 IDLE: start=1 SHALL latch bin into the shift register, clear the BCD scratch register and overflow scratch, load bit counter with BIN_W, and go to SHIFT.
REQ-014 SHALL ignore start while busy=1; there is no queueing and no error flag.
REQ-015 SHIFT: each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one bit, then decrement the counter.
REQ-016 SHALL set overflow scratch sticky if a 1 is shifted out of the top scratch digit on any SHIFT cycle.
REQ-017 SHIFT SHALL last exactly BIN_W cycles, then go to DONE.
REQ-018 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-019 done SHALL rise exactly BIN_W+1 cycles after the cycle in which start was sampled high in IDLE; start is next accepted on the cycle after done.
REQ-020 bcd, overflow and lz_mask SHALL update on the same edge done rises; they hold their values otherwise, including throughout a later conversion.
REQ-021 On overflow=1 bcd SHALL saturate to all digits 9 and lz_mask SHALL be all 0.
REQ-022 lz_mask bit i (i>=1) SHALL be 1 iff digits DIGITS-1 down to i of the result are all 0.
REQ-023 bin=0 SHALL yield bcd all 0 and lz_mask with every bit except bit 0 set.
REQ-024 All arithmetic SHALL be unsigned and 4-bit per digit; no digit exceeds 9 after any SHIFT cycle.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, bcd=0, overflow=0, lz_mask=0, and clear counter and scratch.
REQ-026 Reset asserted mid-conversion SHALL abort it with no done pulse; start in the same cycle as rst_n=0 is ignored.
REQ-027 The first start after reset release SHALL be accepted normally.

Verification
REQ-028 BIN_W=8, DIGITS=3, bin=255, start pulse -> done 9 cycles later, bcd=0x255, overflow=0, lz_mask=000.
REQ-029 BIN_W=8, DIGITS=3, bin=0 -> bcd=0x000, lz_mask=110; bin=7 -> bcd=0x007, lz_mask=110; bin=42 -> bcd=0x042, lz_mask=100.
REQ-030 BIN_W=8, DIGITS=2, bin=100 -> overflow=1, bcd=0x99, lz_mask=00; then bin=99 -> overflow=0, bcd=0x99.
REQ-031 Start bin=12, then start bin=200 three cycles later while busy -> second start ignored, bcd=0x012, exactly one done.
REQ-032 Start bin=200, rst_n=0 on the 4th SHIFT cycle -> no done, all outputs 0; start bin=5 after release -> bcd=0x005.
REQ-033 BIN_W=16, DIGITS=5, bin=65535 -> done 17 cycles after start, bcd=0x65535, overflow=0.
